// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int BURST_CNT_W    = 16;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry holding buffer between the FIFO read port and the stream output.
// Entry order is head (presented) then tail; the state doubles as the occupancy count.
module fifo_rd_skid
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cap,
   input  logic [DATA_WIDTH-1:0] cap_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output buf_state_t            state
);

   buf_state_t            state_q, state_d;
   logic [DATA_WIDTH-1:0] head_q, head_d;
   logic [DATA_WIDTH-1:0] tail_q, tail_d;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         BUF_EMPTY: begin
            if (cap) begin
               head_d  = cap_data;
               state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            case ({cap, pop})
               2'b10: begin
                  tail_d  = cap_data;
                  state_d = BUF_TWO;
               end
               2'b01: state_d = BUF_EMPTY;
               2'b11: head_d = cap_data;
               default: ;
            endcase
         end
         BUF_TWO: begin
            // Issue credits keep a capture from landing here without a pop.
            if (pop) begin
               head_d = tail_q;
               if (cap) tail_d = cap_data;
               else     state_d = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign head  = head_q;
   assign state = state_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO into a valid/ready stream, hiding the one-cycle read latency.
// Optional FIFO_RD_STREAM_STATS_EN adds word_cnt / stall_cnt counters.
module fifo_rd_stream
   import fifo_rd_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int BURST_LEN  = 4,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data_out,
   output logic                  fifo_r_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready
`ifdef FIFO_RD_STREAM_STATS_EN
   ,
   output logic [31:0]           word_cnt,
   output logic [31:0]           stall_cnt
`endif
);

   localparam logic [BURST_CNT_W-1:0] LAST_IDX = BURST_CNT_W'(BURST_LEN - 1);

   buf_state_t             buf_state;
   logic [1:0]             buf_cnt;
   logic                   pop;
   logic [2:0]             occ, lim;
   logic                   inflight_q, inflight_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;

   assign buf_cnt = buf_state;
   assign m_valid = (buf_state != BUF_EMPTY);
   assign pop     = m_valid & m_ready;

   // A read may issue when buffered + in-flight words fit, counting the slot a pop frees now.
   assign occ       = {1'b0, buf_cnt} + {2'b00, inflight_q};
   assign lim       = 3'(BUF_DEPTH) + {2'b00, pop};
   assign fifo_r_en = rst_n & rd_enable & ~fifo_empty & (occ < lim);

   assign m_last = m_valid & (burst_cnt_q == LAST_IDX);

   always_comb begin
      inflight_d  = fifo_r_en;
      burst_cnt_d = burst_cnt_q;
      if (pop)
         burst_cnt_d = (burst_cnt_q == LAST_IDX) ? '0 : burst_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_q  <= 1'b0;
         burst_cnt_q <= '0;
      end else begin
         inflight_q  <= inflight_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   fifo_rd_skid #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst_n    (rst_n),
      .cap      (inflight_q),
      .cap_data (fifo_data_out),
      .pop      (pop),
      .head     (m_data),
      .state    (buf_state)
   );

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0] word_cnt_q, word_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      word_cnt_d  = word_cnt_q + {31'd0, pop};
      stall_cnt_d = stall_cnt_q + {31'd0, m_valid & ~m_ready};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         word_cnt_q  <= word_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign word_cnt  = word_cnt_q;
   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Randomized and directed bench for fifo_rd_stream against a word-count/queue model.
module tb_fifo_rd_stream;

   localparam int DW = 8;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rd_enable = 1'b0;
   logic          fifo_empty = 1'b1;
   logic [DW-1:0] fifo_data_out = '0;
   logic          fifo_r_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_last;
   logic          m_ready = 1'b0;
`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0]   word_cnt, stall_cnt;
`endif

   fifo_rd_stream #(.DATA_WIDTH(DW), .BURST_LEN(BL), .BUF_DEPTH(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rd_enable     (rd_enable),
      .fifo_empty    (fifo_empty),
      .fifo_data_out (fifo_data_out),
      .fifo_r_en     (fifo_r_en),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_last        (m_last),
      .m_ready       (m_ready)
`ifdef FIFO_RD_STREAM_STATS_EN
      ,
      .word_cnt      (word_cnt),
      .stall_cnt     (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Physical FIFO contents and forced-empty override.
   logic [DW-1:0] fq[$];
   bit            force_empty = 1'b0;
   logic [DW-1:0] pend = '0;

   // Model: words captured but not yet delivered, in-flight word, delivered count.
   logic [DW-1:0] exp_q[$];
   bit            infl = 1'b0;
   logic [DW-1:0] infl_word = '0;
   int            pop_cnt = 0;
   int            stall_exp = 0;
   int            cyc = 0;

   // Logs of observed DUT activity for the directed literal checks.
   int            ren_n = 0;
   logic [DW-1:0] dq[$];
   bit            dl[$];
   int            dc[$];
   int            first_ren = -1;
   int            first_vld = -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic clr();
      ren_n = 0;
      dq.delete();
      dl.delete();
      dc.delete();
      first_ren = -1;
      first_vld = -1;
   endtask

   task automatic push(input logic [DW-1:0] w);
      fq.push_back(w);
   endtask

   // One clock cycle: inputs already set (posedge+1), checks at negedge.
   task automatic step();
      bit ev, el, pop, er;
      int occ;
      fifo_empty = force_empty || (fq.size() == 0);
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         chk("rst_r_en", {31'd0, fifo_r_en}, 32'd0);
         chk("rst_valid", {31'd0, m_valid}, 32'd0);
         chk("rst_data", {24'd0, m_data}, 32'd0);
         chk("rst_last", {31'd0, m_last}, 32'd0);
         exp_q.delete();
         infl      = 1'b0;
         pop_cnt   = 0;
         stall_exp = 0;
      end else begin
         ev  = exp_q.size() > 0;
         el  = ev && ((pop_cnt % BL) == BL - 1);
         pop = ev && m_ready;
         occ = exp_q.size() + int'(infl);
         er  = rd_enable && !fifo_empty && (occ < 2 + int'(pop));
         chk("r_en", {31'd0, fifo_r_en}, {31'd0, er});
         chk("valid", {31'd0, m_valid}, {31'd0, ev});
         if (ev) begin
            chk("data", {24'd0, m_data}, {24'd0, exp_q[0]});
            chk("last", {31'd0, m_last}, {31'd0, el});
         end
         if (m_valid && m_ready) begin
            dq.push_back(m_data);
            dl.push_back(m_last);
            dc.push_back(cyc);
         end
         if (m_valid && first_vld < 0) first_vld = cyc;
         if (fifo_r_en) begin
            ren_n++;
            if (first_ren < 0) first_ren = cyc;
         end
         if (ev && !m_ready) stall_exp++;
         if (pop) begin
            void'(exp_q.pop_front());
            pop_cnt++;
         end
         if (infl) exp_q.push_back(infl_word);
      end
      infl = 1'b0;
      if (fifo_r_en && fq.size() > 0) begin
         pend      = fq.pop_front();
         infl_word = pend;
         infl      = rst_n;
      end
      @(posedge clk);
      #1;
      fifo_data_out = pend;
   endtask

   initial begin
      // Reset held with data available and consumer ready.
      for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
      force_empty = 1'b0;
      rd_enable   = 1'b1;
      m_ready     = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("rst_fifo_untouched", fq.size(), 4);

      // Full rate.
      clr();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("fr_ren_n", ren_n, 4);
      chk("fr_latency", first_vld - first_ren, 2);
      chk("fr_n", dq.size(), 4);
      for (int i = 0; i < dq.size() && i < 4; i++) begin
         chk("fr_data", {24'd0, dq[i]}, 32'h11 + i);
         chk("fr_last", {31'd0, dl[i]}, (i == 3) ? 32'd1 : 32'd0);
      end

      // Backpressure.
      clr();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h11 + 8'(i));
      for (int i = 0; i < 6; i++) step();
      chk("bp_ren_n", ren_n, 2);
      chk("bp_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_data", {24'd0, m_data}, 32'h11);
      m_ready = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("bp_ren_total", ren_n, 4);
      chk("bp_n", dq.size(), 4);
      if (dq.size() == 4) begin
         for (int i = 0; i < 4; i++) chk("bp_order", {24'd0, dq[i]}, 32'h11 + i);
         chk("bp_gapless", dc[3] - dc[0], 3);
         chk("bp_last", {31'd0, dl[3]}, 32'd1);
      end

      // Empty guard.
      clr();
      push(8'h21);
      force_empty = 1'b1;
      for (int i = 0; i < 5; i++) step();
      chk("eg_no_ren", ren_n, 0);
      force_empty = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("eg_one_ren", ren_n, 1);
      chk("eg_one_word", dq.size(), 1);
      if (dq.size() > 0) chk("eg_word", {24'd0, dq[0]}, 32'h21);

      // Pause after second read.
      clr();
      for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
      for (int i = 0; i < 20 && ren_n < 2; i++) step();
      chk("pz_wait", ren_n, 2);
      rd_enable = 1'b0;
      for (int i = 0; i < 6; i++) step();
      chk("pz_ren_held", ren_n, 2);
      chk("pz_drained", dq.size(), 2);
      rd_enable = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk("pz_ren_total", ren_n, 4);
      chk("pz_n", dq.size(), 4);
      if (dq.size() == 4) begin
         chk("pz_w3", {24'd0, dq[2]}, 32'h33);
         chk("pz_w4", {24'd0, dq[3]}, 32'h34);
      end

      // Reset mid-burst: one word buffered, one in flight.
      clr();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h41 + 8'(i));
      for (int i = 0; i < 20 && ren_n < 2; i++) step();
      chk("rm_wait", ren_n, 2);
      chk("rm_buffered", {31'd0, m_valid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rm_valid_clr", {31'd0, m_valid}, 32'd0);
      chk("rm_data_clr", {24'd0, m_data}, 32'd0);
      chk("rm_ren_clr", {31'd0, fifo_r_en}, 32'd0);
      for (int i = 0; i < 2; i++) step();
      fq.delete();
      for (int i = 0; i < 4; i++) push(8'h51 + 8'(i));
      m_ready = 1'b1;
      clr();
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step();
      chk("rm_n", dq.size(), 4);
      if (dq.size() == 4)
         for (int i = 0; i < 4; i++) begin
            chk("rm_data", {24'd0, dq[i]}, 32'h51 + i);
            chk("rm_last", {31'd0, dl[i]}, (i == 3) ? 32'd1 : 32'd0);
         end

      // Randomized traffic.
      clr();
      begin
         int pushed = 0;
         for (int i = 0; i < 3000; i++) begin
            rd_enable   = ($urandom_range(0, 9) < 8);
            m_ready     = ($urandom_range(0, 9) < 7);
            force_empty = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1 && fq.size() < 8) begin
               push(8'($urandom));
               pushed++;
            end
            step();
         end
         rd_enable   = 1'b1;
         m_ready     = 1'b1;
         force_empty = 1'b0;
         for (int i = 0; i < 30; i++) step();
         chk("rnd_fifo_drained", fq.size(), 0);
         chk("rnd_model_drained", exp_q.size(), 0);
         chk("rnd_delivered", dq.size(), pushed);
      end
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("word_cnt", word_cnt, pop_cnt);
      chk("stall_cnt", stall_cnt, stall_exp);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side drain engine for the team's synchronous FIFO. It issues r_en pulses to the FIFO, captures the registered data_out, and presents the words as a valid/ready stream with backpressure. It sits between the FIFO read port and any downstream consumer. The consumer never sees FIFO read latency, and no word is lost or duplicated.

Parameters:
DATA_WIDTH, 8, width of FIFO data and stream data
BURST_LEN, 4, words per burst; m_last marks every BURST_LEN-th delivered word; legal range 1..65535
BUF_DEPTH, 2, internal holding buffer entries; fixed at 2, provides full throughput

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
rd_enable  in  1  1 = allow new FIFO reads; 0 = pause issuing, still deliver buffered words
fifo_empty  in  1  FIFO empty flag
fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_r_en
fifo_r_en  out  1  FIFO read strobe, one word per cycle high
m_data  out  DATA_WIDTH  stream data
m_valid  out  1  stream valid
m_last  out  1  last word of burst, qualified by m_valid
m_ready  in  1  stream ready from consumer

Behaviour:
- Reset (rst_n low, async):
  - fifo_r_en, m_valid, m_last = 0; m_data = 0.
  - Buffer count, in-flight flag and burst counter = 0.
  - A word in flight at reset is discarded.
- FIFO timing:
  - fifo_r_en high in cycle N means fifo_data_out holds that word in cycle N+1.
  - The word is written into the buffer at the end of cycle N+1.
- Handshake terms:
  - pop = m_valid & m_ready.
  - credits = BUF_DEPTH - buf_cnt - inflight + pop.
- Issue rule:
  - fifo_r_en = rd_enable & ~fifo_empty & (credits > 0), combinational from registered state plus m_ready.
  - fifo_r_en is never high while fifo_empty = 1.
- inflight register: set to 1 at the end of any cycle with fifo_r_en = 1, else cleared.
- Buffer: 2-entry FIFO whose state is buf_cnt (EMPTY=0, ONE=1, TWO=2).
  - EMPTY→ONE on capture without pop.
  - ONE→TWO on capture without pop.
  - ONE→EMPTY on pop without capture.
  - TWO→ONE on pop (capture cannot coincide, since credits forbid it).
  - Capture and pop in the same cycle: count unchanged, order preserved.
- Output:
  - m_valid = (buf_cnt != 0); m_data = head entry.
  - m_data and m_last are held stable while m_valid & ~m_ready (AXI-style rule: no retraction, no change).
- Latency: 2 cycles from fifo_r_en to m_valid with an empty buffer.
- Throughput: sustained 1 word/cycle when the FIFO is non-empty and m_ready = 1.
- Burst counter, 16 bits:
  - Increments on each pop.
  - m_last = m_valid & (burst_cnt == BURST_LEN-1).
  - The counter wraps to 0 on the pop of an m_last word.
  - BURST_LEN = 1 gives m_last on every word.
- rd_enable deassert mid-stream: an in-flight word is still captured, and buffered words still drain.
- fifo_empty asserting with a read in flight: that word is still captured; issuing stops.

Optional Feature:
Macro FIFO_RD_STREAM_STATS_EN.
- Defined: adds output port word_cnt [31:0], count of pops.
  - Wraps at 2^32.
  - Reset to 0.
  - Also adds output stall_cnt [31:0], counting cycles with m_valid & ~m_ready.
- Not defined: neither port exists and no counter logic is present. Behaviour is otherwise identical.

Decomposition:
- Package fifo_rd_pkg:
  - DATA_WIDTH default constant.
  - typedef of buf_state_t {BUF_EMPTY, BUF_ONE, BUF_TWO}.
  - BURST_CNT_W = 16.
- One sub-module: fifo_rd_skid, the 2-entry holding buffer with capture/pop/count. The issue logic, burst counter and stats stay in the top.

Test Plan:
- Reset: hold rst_n = 0 with fifo_empty = 0 → fifo_r_en = 0, m_valid = 0, m_data = 0, m_last = 0 throughout.
- Full rate, with FIFO preloaded 0x11,0x12,0x13,0x14 and m_ready = 1, BURST_LEN = 4:
  - fifo_r_en high 4 consecutive cycles.
  - m_valid high from 2 cycles after the first r_en, with data 0x11..0x14 back-to-back.
  - m_last only with 0x14.
- Backpressure, 4 words preloaded, m_ready = 0:
  - Exactly 2 r_en pulses, then none.
  - m_data stays 0x11 stable.
  - Raise m_ready → 0x11,0x12,0x13,0x14 in order, no gaps after first, no duplicates.
- Empty guard: fifo_empty = 1 with rd_enable = 1 → fifo_r_en never asserts.
  - 1 word then empty → exactly 1 pulse; m_valid for exactly 1 handshake.
- Pause: drop rd_enable after the 2nd r_en → no further r_en; both words delivered; restoring rd_enable resumes with word 3.
- Reset mid-burst: assert rst_n = 0 after 2 of 4 words, with 1 buffered and 1 in flight → outputs clear immediately.
  - After release, with 4 fresh words, m_last lands on the 4th new word.
